mario_pal_arb: RTL and testbench

- Time-slot arbiter for a single-port synchronous 512x8 palette RAM, which replaces the dual-port colour PROM.
- Shares the RAM between video pixel lookups (one per 6 MHz pixel) and palette download writes. Download writes are buffered in a small FIFO and drained in the free 24 MHz slots between pixel reads and during composite blanking.
- Sits between the sprite/background mux latch and the 3R:3G:2B video output.

---
 rtl/mario_pal_pkg.sv | 20 ++
 rtl/mario_pal_fifo.sv | 61 ++++++
 rtl/mario_pal_arb.sv | 159 +++++++++++++++
 tb/tb_mario_pal_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mario_pal_pkg.sv
// Shared widths, arbitration slot encoding and write-buffer entry type
// for the palette RAM arbiter.
package mario_pal_pkg;

    localparam int PAL_AW = 9;
    localparam int PAL_DW = 8;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_VIDEO,
        SLOT_WRITE,
        SLOT_RB
    } slot_e;

    typedef struct packed {
        logic [PAL_AW-1:0] addr;
        logic [PAL_DW-1:0] data;
    } pal_wr_t;

endpackage

// File: rtl/mario_pal_fifo.sv
// Download write buffer: synchronous FIFO with push/pop, full/empty
// and occupancy count. Push at full is accepted only with a pop.
module mario_pal_fifo
    import mario_pal_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  pal_wr_t       din_i,
    input  logic          pop_i,
    output pal_wr_t       dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    pal_wr_t       mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(FIFO_DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mario_pal_arb.sv
// Time-slot arbiter sharing a single-port 512x8 palette RAM between pixel
// lookups and buffered download writes. Optional readback: MARIO_PAL_READBACK_EN.
module mario_pal_arb
    import mario_pal_pkg::*;
#(
    parameter int   FIFO_DEPTH = 4,
    parameter logic CL2        = 1'b1
) (
    input  logic              I_CLK_24M,
    input  logic              I_RESETn,
    input  logic              I_CEN6,
    input  logic [7:0]        I_PIX_AB,
    input  logic              I_CMPBLKn,
    input  logic              I_DL_WR,
    input  logic [PAL_AW-1:0] I_DL_ADDR,
    input  logic [PAL_DW-1:0] I_DL_DATA,
    output logic              O_DL_FULL,
    output logic              O_DL_OVF,
    output logic [PAL_AW-1:0] O_RAM_A,
    output logic [PAL_DW-1:0] O_RAM_D,
    output logic              O_RAM_WE,
    input  logic [PAL_DW-1:0] I_RAM_Q,
    output logic [2:0]        O_R,
    output logic [2:0]        O_G,
    output logic [1:0]        O_B
`ifdef MARIO_PAL_READBACK_EN
    ,
    input  logic              I_RB_REQ,
    input  logic [PAL_AW-1:0] I_RB_ADDR,
    output logic              O_RB_ACK,
    output logic [PAL_DW-1:0] O_RB_DATA
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    pal_wr_t           wr_in;
    pal_wr_t           fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [CW-1:0]     fifo_cnt;
    logic              at_cap;

    slot_e             slot;
    logic              vid_slot;
    logic              blank_pix;
    logic              rb_go;

    logic [PAL_AW-1:0] ram_a_q, ram_a_d;
    logic [PAL_DW-1:0] ram_d_q, ram_d_d;
    logic              ram_we;
    logic              vid_pend_q;
    logic              ovf_q;
    logic [7:0]        col_q;

    assign wr_in.addr = I_DL_ADDR;
    assign wr_in.data = I_DL_DATA;

    mario_pal_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (I_CLK_24M),
        .rst_ni (I_RESETn),
        .push_i (I_DL_WR),
        .din_i  (wr_in),
        .pop_i  (fifo_pop),
        .dout_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    assign at_cap    = (fifo_cnt == CW'(FIFO_DEPTH));
    assign vid_slot  = I_CEN6 & I_CMPBLKn;
    assign blank_pix = I_CEN6 & ~I_CMPBLKn;

`ifdef MARIO_PAL_READBACK_EN
    logic              rb_pend_q;
    logic [PAL_DW-1:0] rb_data_q;

    // Requester holds REQ through the ack cycle, so mask it while pending.
    assign rb_go     = I_RB_REQ & ~rb_pend_q;
    assign O_RB_ACK  = rb_pend_q;
    assign O_RB_DATA = rb_data_q;

    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            rb_pend_q <= 1'b0;
            rb_data_q <= '0;
        end else begin
            rb_pend_q <= (slot == SLOT_RB);
            if (rb_pend_q) rb_data_q <= I_RAM_Q;
        end
    end
`else
    assign rb_go = 1'b0;
`endif

    always_comb begin
        slot = SLOT_IDLE;
        if (vid_slot)
            slot = SLOT_VIDEO;
        else if (!fifo_empty)
            slot = SLOT_WRITE;
        else if (rb_go)
            slot = SLOT_RB;
    end

    always_comb begin
        ram_a_d  = ram_a_q;
        ram_d_d  = ram_d_q;
        ram_we   = 1'b0;
        fifo_pop = 1'b0;
        unique case (slot)
            SLOT_VIDEO: ram_a_d = {CL2, I_PIX_AB};
            SLOT_WRITE: begin
                ram_a_d  = fifo_head.addr;
                ram_d_d  = fifo_head.data;
                ram_we   = 1'b1;
                fifo_pop = 1'b1;
            end
`ifdef MARIO_PAL_READBACK_EN
            SLOT_RB:    ram_a_d = I_RB_ADDR;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            ram_a_q    <= '0;
            ram_d_q    <= '0;
            vid_pend_q <= 1'b0;
            col_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            vid_pend_q <= vid_slot;
            if (vid_pend_q)
                col_q <= I_RAM_Q;
            else if (blank_pix)
                col_q <= '0;
            if (I_DL_WR && at_cap && !fifo_pop)
                ovf_q <= 1'b1;
        end
    end

    assign O_RAM_A   = ram_a_d;
    assign O_RAM_D   = ram_d_d;
    assign O_RAM_WE  = ram_we;
    assign O_DL_FULL = fifo_full;
    assign O_DL_OVF  = ovf_q;
    assign O_R       = col_q[7:5];
    assign O_G       = col_q[4:2];
    assign O_B       = col_q[1:0];

endmodule

// File: tb/tb_mario_pal_arb.sv
// Scoreboard bench for mario_pal_arb: queue-based reference of the write
// buffer and palette image, with a behavioural write-first RAM attached.
module tb_mario_pal_arb;

    localparam int   DEPTH  = 4;
    localparam logic TB_CL2 = 1'b1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cen6 = 1'b0;
    logic [7:0] pixab = '0;
    logic       cmpblkn = 1'b0;
    logic       dlwr = 1'b0;
    logic [8:0] dladdr = '0;
    logic [7:0] dldata = '0;
    logic       dl_full, dl_ovf;
    logic [8:0] ram_a;
    logic [7:0] ram_d;
    logic       ram_we;
    logic [7:0] ram_q = 8'h00;
    logic [2:0] o_r, o_g;
    logic [1:0] o_b;

    always #5 clk = ~clk;

    mario_pal_arb #(.FIFO_DEPTH(DEPTH), .CL2(TB_CL2)) dut (
        .I_CLK_24M(clk),
        .I_RESETn (rstn),
        .I_CEN6   (cen6),
        .I_PIX_AB (pixab),
        .I_CMPBLKn(cmpblkn),
        .I_DL_WR  (dlwr),
        .I_DL_ADDR(dladdr),
        .I_DL_DATA(dldata),
        .O_DL_FULL(dl_full),
        .O_DL_OVF (dl_ovf),
        .O_RAM_A  (ram_a),
        .O_RAM_D  (ram_d),
        .O_RAM_WE (ram_we),
        .I_RAM_Q  (ram_q),
        .O_R      (o_r),
        .O_G      (o_g),
        .O_B      (o_b)
    );

    // Synchronous single-port RAM, write-first, one-cycle read latency.
    logic [7:0] ram_mem [512] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_a] <= ram_d;
            ram_q          <= ram_d;
        end else begin
            ram_q <= ram_mem[ram_a];
        end
    end

    typedef struct {
        int         due;
        bit         we;
        logic [8:0] a;
        logic [7:0] d;
    } acc_t;

    typedef struct {
        int         due;
        logic [7:0] c;
    } col_t;

    acc_t        acc_q[$];
    col_t        colq[$];
    logic [16:0] mq[$];
    logic [7:0]  ref_mem [512];
    bit          m_ovf = 1'b0;
    bit          e_full = 1'b0;
    bit          e_ovf = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  cur_col = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the model applies the arbitration rules.
    task automatic step(input bit cen, input logic [7:0] pix, input bit blk,
                        input bit wr, input logic [8:0] wa,
                        input logic [7:0] wd);
        acc_t        t;
        col_t        c;
        logic [16:0] e;
        @(negedge clk);
        cen6    = cen;
        pixab   = pix;
        cmpblkn = blk;
        dlwr    = wr;
        dladdr  = wa;
        dldata  = wd;
        e_full  = (mq.size() == DEPTH);
        e_ovf   = m_ovf;
        if (cen && blk) begin
            t.due = cyc; t.we = 1'b0; t.a = {TB_CL2, pix}; t.d = 8'h00;
            acc_q.push_back(t);
            c.due = cyc + 2; c.c = ref_mem[{TB_CL2, pix}];
            colq.push_back(c);
        end else begin
            if (cen) begin
                c.due = cyc + 1; c.c = 8'h00;
                colq.push_back(c);
            end
            if (mq.size() > 0) begin
                e = mq.pop_front();
                t.due = cyc; t.we = 1'b1; t.a = e[16:8]; t.d = e[7:0];
                acc_q.push_back(t);
                ref_mem[e[16:8]] = e[7:0];
            end
        end
        if (wr) begin
            if (mq.size() < DEPTH) mq.push_back({wa, wd});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n, input bit blk);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, blk, 1'b0, 9'h0, 8'h0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rstn = 1'b0;
        cen6 = 1'b0; dlwr = 1'b0; cmpblkn = 1'b1;
        mq.delete(); acc_q.delete(); colq.delete();
        m_ovf = 1'b0; e_full = 1'b0; e_ovf = 1'b0;
        #1;
        chk("rst_ovf", 32'(dl_ovf), 32'd0);
        chk("rst_full", 32'(dl_full), 32'd0);
        chk("rst_colour", 32'({o_r, o_g, o_b}), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        repeat (n) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: compares every cycle against what the driver queued.
    always @(negedge clk) begin
        acc_t a;
        col_t c;
        #2;
        if (!rstn) cur_col = 8'h00;
        if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
            a = acc_q.pop_front();
            chk("ram_we", 32'(ram_we), 32'(a.we));
            chk("ram_a", 32'(ram_a), 32'(a.a));
            if (a.we) chk("ram_d", 32'(ram_d), 32'(a.d));
        end else begin
            chk("ram_we_idle", 32'(ram_we), 32'd0);
        end
        if (colq.size() > 0 && colq[0].due == cyc) begin
            c = colq.pop_front();
            cur_col = c.c;
        end
        chk("colour", 32'({o_r, o_g, o_b}), 32'(cur_col));
        chk("dl_full", 32'(dl_full), 32'(e_full));
        chk("dl_ovf", 32'(dl_ovf), 32'(e_ovf));
    end

    initial begin
        int gap;
        bit cen;
        bit blk;
        bit wr;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle(2, 1'b1);

        // Download during blank, then look it up: write lands first.
        step(1'b0, 8'h00, 1'b0, 1'b1, 9'h105, 8'hE3);
        step(1'b0, 8'h00, 1'b0, 1'b0, 9'h0, 8'h0);
        step(1'b1, 8'h05, 1'b1, 1'b0, 9'h0, 8'h0);
        idle(2, 1'b1);
        chk("tp_first_colour", 32'({o_r, o_g, o_b}), 32'h0E3);

        // Blanked pixel clears colour while a queued write drains.
        step(1'b0, 8'h00, 1'b1, 1'b1, 9'h1F0, 8'h3C);
        step(1'b1, 8'h10, 1'b0, 1'b0, 9'h0, 8'h0);
        idle(1, 1'b1);
        chk("tp_blank_colour", 32'({o_r, o_g, o_b}), 32'd0);

        // Burst of six during active video, pixel every 4th cycle.
        for (int i = 0; i < 6; i++)
            step(i % 4 == 0, 8'($urandom), 1'b1, 1'b1, 9'(9'h140 + i),
                 8'($urandom));
        idle(4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 9'h0, 8'h0);
            step(1'b0, 8'h00, 1'b1, 1'b0, 9'h0, 8'h0);
        end
        idle(2, 1'b1);
        chk("tp_burst_ovf", 32'(dl_ovf), 32'd0);

        // Pixel every other cycle while pushing back-to-back: overflow.
        for (int i = 0; i < 10; i++)
            step(i % 2 == 0, 8'(8'h60 + i), 1'b1, 1'b1, 9'(9'h160 + i),
                 8'($urandom));
        idle(8, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 9'h0, 8'h0);
            step(1'b0, 8'h00, 1'b1, 1'b0, 9'h0, 8'h0);
        end
        idle(2, 1'b1);
        chk("tp_full_ovf", 32'(dl_ovf), 32'd1);

        // Reset with three entries still buffered.
        for (int i = 0; i < 6; i++)
            step(i % 2 == 0, 8'h00, 1'b1, 1'b1, 9'(9'h180 + i), 8'(8'hA0 + i));
        do_reset(2);
        idle(6, 1'b1);

        // Randomised traffic with blanking phases and dense bursts.
        gap = 4;
        for (int i = 0; i < 1500; i++) begin
            cen = (gap >= 3) || (gap >= 1 && $urandom_range(0, 7) == 0);
            gap = cen ? 0 : gap + 1;
            blk = ((i / 200) % 4) != 3;
            wr  = ((i / 100) % 5 == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
            step(cen, 8'($urandom_range(0, 15)), blk, wr,
                 {1'($urandom), 8'($urandom_range(0, 15))}, 8'($urandom));
        end
        idle(10, 1'b1);
        chk("acc_drained", 32'(acc_q.size()), 32'd0);
        chk("colour_drained", 32'(colq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
